// File: rtl/stream_trim_pkg.sv
// Shared types and constants for the pad-trim stream blocks.
package stream_trim_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef logic [2:0] state_t;
  localparam state_t S_LEAD   = 3'd0;
  localparam state_t S_BODY   = 3'd1;
  localparam state_t S_EMIT_H = 3'd2;
  localparam state_t S_PADS   = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;

  // Held character at the default 8-bit width; wider builds declare their own.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } held_t;

endpackage

// File: rtl/pad_run_counter.sv
// Saturating pending-pad run counter with sticky overflow.
module pad_run_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             sat,
  output logic             overflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign cnt      = cnt_q;
  assign zero     = (cnt_q == '0);
  assign sat      = &cnt_q;
  assign overflow = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // A pad arriving at saturation is dropped; only the flag records it.
      if (sat) ovf_d = 1'b1;
      else     cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/stream_pad_trim.sv
// Strips leading/trailing pad characters from each frame of a valid/ready stream.
// Define STREAM_PAD_TRIM_COLLAPSE_EN to collapse interior pad runs to a single pad.
module stream_pad_trim
  import stream_trim_pkg::*;
#(
  parameter int unsigned       DATA_W         = 8,
  parameter logic [DATA_W-1:0] PAD_CHAR       = DATA_W'(ASCII_SPACE),
  parameter int unsigned       CNT_W          = 8,
  parameter bit                STRIP_LEADING  = 1'b1,
  parameter bit                STRIP_TRAILING = 1'b1
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic [DATA_W-1:0] In_Data_DI,
  input  logic              In_Valid_SI,
  input  logic              In_Last_SI,
  output logic              In_Ready_SO,
  output logic [DATA_W-1:0] Out_Data_DO,
  output logic              Out_Valid_SO,
  output logic              Out_Last_SO,
  input  logic              Out_Ready_SI,
  output logic              EmptyFrame_SO,
  output logic              Overflow_SO
);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } hchar_t;

  state_t           state_q, state_d;
  hchar_t           h_q, h_d;
  hchar_t           n_q, n_d;
  logic             empty_q, empty_d;
  logic             is_pad, lead_pad, body_pad;
  logic             cnt_inc, cnt_dec, cnt_clr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero, cnt_sat;

  assign is_pad        = (In_Data_DI == PAD_CHAR);
  assign lead_pad      = STRIP_LEADING && is_pad;
  assign body_pad      = STRIP_TRAILING && is_pad;
  assign EmptyFrame_SO = empty_q;

  pad_run_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (Clk_CI),
    .rst_n    (Rst_RBI),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .cnt      (cnt),
    .zero     (cnt_zero),
    .sat      (cnt_sat),
    .overflow (Overflow_SO)
  );

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    n_d          = n_q;
    empty_d      = 1'b0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;
    In_Ready_SO  = 1'b0;
    Out_Valid_SO = 1'b0;
    Out_Data_DO  = '0;
    Out_Last_SO  = 1'b0;
    case (state_q)
      S_LEAD: begin
        In_Ready_SO = 1'b1;
        if (In_Valid_SI) begin
          if (lead_pad) begin
            empty_d = In_Last_SI;
          end else begin
            h_d     = '{last: In_Last_SI, data: In_Data_DI};
            state_d = In_Last_SI ? S_DRAIN : S_BODY;
          end
        end
      end
      S_BODY: begin
        // Pad-free text streams through H at one beat per cycle.
        In_Ready_SO = (!body_pad && cnt_zero) ? Out_Ready_SI : 1'b1;
        if (In_Valid_SI) begin
          if (body_pad) begin
            if (In_Last_SI) begin
              h_d.last = 1'b1;
              cnt_clr  = 1'b1;
              state_d  = S_DRAIN;
            end else begin
              cnt_inc = 1'b1;
            end
          end else if (cnt_zero) begin
            Out_Valid_SO = 1'b1;
            Out_Data_DO  = h_q.data;
            if (Out_Ready_SI) begin
              h_d = '{last: In_Last_SI, data: In_Data_DI};
              if (In_Last_SI) state_d = S_DRAIN;
            end
          end else begin
            n_d     = '{last: In_Last_SI, data: In_Data_DI};
            state_d = S_EMIT_H;
          end
        end
      end
      S_EMIT_H: begin
        Out_Valid_SO = 1'b1;
        Out_Data_DO  = h_q.data;
        if (Out_Ready_SI) state_d = S_PADS;
      end
      S_PADS: begin
        Out_Valid_SO = 1'b1;
        Out_Data_DO  = PAD_CHAR;
        if (Out_Ready_SI) begin
`ifdef STREAM_PAD_TRIM_COLLAPSE_EN
          cnt_clr = 1'b1;
          h_d     = n_q;
          state_d = n_q.last ? S_DRAIN : S_BODY;
`else
          cnt_dec = 1'b1;
          if (cnt == CNT_W'(1)) begin
            h_d     = n_q;
            state_d = n_q.last ? S_DRAIN : S_BODY;
          end
`endif
        end
      end
      S_DRAIN: begin
        Out_Valid_SO = 1'b1;
        Out_Data_DO  = h_q.data;
        Out_Last_SO  = 1'b1;
        if (Out_Ready_SI) begin
          h_d     = '0;
          state_d = S_LEAD;
        end
      end
      default: state_d = S_LEAD;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= S_LEAD;
      h_q     <= '0;
      n_q     <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      n_q     <= n_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_stream_pad_trim.sv
// Self-checking bench for stream_pad_trim: directed table, corner sequences, random frames.
module tb_stream_pad_trim;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam logic [7:0] PAD = 8'h20;
  localparam int LIMIT = 20000;

  typedef logic [7:0] ch_t;
  typedef ch_t        ch_q_t[$];
  typedef logic [8:0] beat_t;
  typedef beat_t      beat_q_t[$];

  typedef struct {
    string in_s;
    string exp_s;
    int    emp;
  } vec_t;

  logic       clk, rst_n;
  logic [7:0] in_data, out_data;
  logic       in_valid, in_last, in_ready;
  logic       out_valid, out_last, out_ready;
  logic       empty, ovf;

  int      tests, fails;
  beat_q_t src_q, out_q;
  int      out_cyc_q[$];
  int      empty_cnt;

  stream_pad_trim dut (
    .Clk_CI        (clk),
    .Rst_RBI       (rst_n),
    .In_Data_DI    (in_data),
    .In_Valid_SI   (in_valid),
    .In_Last_SI    (in_last),
    .In_Ready_SO   (in_ready),
    .Out_Data_DO   (out_data),
    .Out_Valid_SO  (out_valid),
    .Out_Last_SO   (out_last),
    .Out_Ready_SI  (out_ready),
    .EmptyFrame_SO (empty),
    .Overflow_SO   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_q(input string name, input beat_q_t act, input beat_q_t exp);
    int bad;
    bad = -1;
    tests++;
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      if (bad < 0 && act[i] !== exp[i]) bad = i;
    if (bad < 0 && act.size() != exp.size()) bad = (act.size() < exp.size()) ? act.size() : exp.size();
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: %0d beats, expected %0d; first diff at beat %0d got {last,data}=0x%0h expected 0x%0h",
               name, act.size(), exp.size(), bad,
               (bad < act.size()) ? act[bad] : 9'h1ff, (bad < exp.size()) ? exp[bad] : 9'h1ff);
    end
  endtask

  function automatic beat_q_t str_beats(input string s);
    beat_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back({(i == s.len() - 1), s[i]});
    return q;
  endfunction

  task automatic add_frame(input ch_q_t f);
    for (int i = 0; i < f.size(); i++) src_q.push_back({(i == f.size() - 1), f[i]});
  endtask

  function automatic ch_q_t str_chars(input string s);
    ch_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: keep the span from first to last non-pad; interior runs are capped
  // by the counter range (or collapsed to one pad); overflow when a counted run exceeds it.
  function automatic void model(input ch_q_t f, output beat_q_t o, output bit emp, output bit ovf_o);
    int first, lastnp, run, npad, trail;
    first = -1; lastnp = -1; run = 0; ovf_o = 1'b0;
    o = {};
    for (int i = 0; i < f.size(); i++)
      if (f[i] != PAD) begin
        if (first < 0) first = i;
        lastnp = i;
      end
    emp = (first < 0);
    if (first >= 0) begin
      for (int i = first; i <= lastnp; i++) begin
        if (f[i] == PAD) run++;
        else begin
          if (run > MAXC) ovf_o = 1'b1;
`ifdef STREAM_PAD_TRIM_COLLAPSE_EN
          npad = (run > 0) ? 1 : 0;
`else
          npad = (run > MAXC) ? MAXC : run;
`endif
          for (int k = 0; k < npad; k++) o.push_back({1'b0, PAD});
          o.push_back({(i == lastnp), f[i]});
          run = 0;
        end
      end
      trail = f.size() - 1 - lastnp;
      if (trail > 0 && trail - 1 > MAXC) ovf_o = 1'b1;
    end
  endfunction

  // rdy_pct < 0 toggles Out_Ready every cycle.
  task automatic run_stream(input string name, input int gap_pct, input int rdy_pct, input int exp_n);
    int idx, cyc, quiet;
    bit vld, tog;
    idx = 0; cyc = 0; quiet = 0; vld = 0; tog = 1;
    out_q.delete(); out_cyc_q.delete(); empty_cnt = 0;
    while (cyc < LIMIT && !(idx == src_q.size() && out_q.size() >= exp_n && quiet >= 4)) begin
      @(negedge clk);
      if (!vld && idx < src_q.size() && $urandom_range(99, 0) >= gap_pct) vld = 1;
      if (vld) begin
        in_valid = 1'b1;
        {in_last, in_data} = src_q[idx];
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom_range(255, 0));
      end
      if (rdy_pct < 0) begin
        out_ready = tog;
        tog = !tog;
      end else begin
        out_ready = ($urandom_range(99, 0) < rdy_pct);
      end
      #1;
      if (in_valid && in_ready) begin
        idx++;
        vld = 0;
      end
      if (out_valid && out_ready) begin
        out_q.push_back({out_last, out_data});
        out_cyc_q.push_back(cyc);
      end
      if (empty) empty_cnt++;
      if (idx == src_q.size() && out_q.size() >= exp_n) quiet++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b0;
    chk({name, "_timeout"}, (cyc >= LIMIT), 0);
  endtask

  vec_t    tbl[8];
  beat_q_t exp_q, fexp;
  ch_q_t   fr;
  bit      femp, fovf, exp_ovf;
  int      exp_empty, span;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_empty",     empty,     0);
    chk("rst_overflow",  ovf,       0);
    @(negedge clk) rst_n = 1'b1;

`ifdef STREAM_PAD_TRIM_COLLAPSE_EN
    tbl[0] = '{"  AB  C  ", "AB C", 0};
    tbl[7] = '{"A B  C",    "A B C", 0};
`else
    tbl[0] = '{"  AB  C  ", "AB  C", 0};
    tbl[7] = '{"A B  C",    "A B  C", 0};
`endif
    tbl[1] = '{"   ",  "",     1};
    tbl[2] = '{"ABCD", "ABCD", 0};
    tbl[3] = '{"Q",    "Q",    0};
    tbl[4] = '{" Q",   "Q",    0};
    tbl[5] = '{"Q ",   "Q",    0};
    tbl[6] = '{" ",    "",     1};
    for (int i = 0; i < 8; i++) begin
      src_q.delete();
      add_frame(str_chars(tbl[i].in_s));
      exp_q = str_beats(tbl[i].exp_s);
      run_stream($sformatf("tbl%0d", i), 20, 70, exp_q.size());
      chk_q($sformatf("tbl%0d_out", i), out_q, exp_q);
      chk($sformatf("tbl%0d_empty", i), empty_cnt, tbl[i].emp);
    end

    // Full throughput on pad-free text.
    src_q.delete();
    add_frame(str_chars("ABCD"));
    run_stream("abcd", 0, 100, 4);
    chk_q("abcd_out", out_q, str_beats("ABCD"));
    span = (out_cyc_q.size() == 4) ? out_cyc_q[3] - out_cyc_q[0] : -1;
    chk("abcd_span", span, 3);

    // Backpressure toggling every cycle.
    src_q.delete();
    add_frame(str_chars("A B C"));
    run_stream("toggle", 0, -1, 5);
    chk_q("toggle_out", out_q, str_beats("A B C"));

    // Random back-to-back frames against the reference.
    src_q.delete(); exp_q.delete(); exp_empty = 0; exp_ovf = 0;
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      for (int k = 0; k < $urandom_range(12, 1); k++)
        fr.push_back(($urandom_range(2, 0) == 0) ? PAD : 8'(8'h41 + $urandom_range(3, 0)));
      add_frame(fr);
      model(fr, fexp, femp, fovf);
      foreach (fexp[j]) exp_q.push_back(fexp[j]);
      exp_empty += femp;
      exp_ovf |= fovf;
    end
    run_stream("rand", 30, 60, exp_q.size());
    chk_q("rand_out", out_q, exp_q);
    chk("rand_empty", empty_cnt, exp_empty);
    chk("rand_overflow", ovf, exp_ovf);

    // Reset mid-frame: "X " then "Z" pushes the FSM into a registered output state.
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_last = 1'b0; in_data = "X";
    @(negedge clk); in_data = PAD;
    @(negedge clk); in_data = "Z";
    @(negedge clk); in_valid = 1'b0;
    #1;
    chk("mid_out_valid_before", out_valid, 1);
    chk("mid_out_data_before", out_data, "X");
    #1 rst_n = 1'b0;
    #1;
    chk("mid_out_valid_async", out_valid, 0);
    chk("mid_in_ready_async", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    src_q.delete();
    add_frame(str_chars("Y"));
    run_stream("after_rst", 0, 100, 1);
    chk_q("after_rst_out", out_q, str_beats("Y"));

    // Long interior run saturates the counter.
    src_q.delete(); fr.delete();
    fr.push_back("A");
    for (int k = 0; k < 300; k++) fr.push_back(PAD);
    fr.push_back("B");
    add_frame(fr);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h41});
`ifdef STREAM_PAD_TRIM_COLLAPSE_EN
    exp_q.push_back({1'b0, PAD});
`else
    for (int k = 0; k < 255; k++) exp_q.push_back({1'b0, PAD});
`endif
    exp_q.push_back({1'b1, 8'h42});
    run_stream("ovf", 0, 100, exp_q.size());
    chk_q("ovf_out", out_q, exp_q);
    chk("ovf_flag", ovf, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
